// File: rtl/outlier_split.sv
// Buffers one tile, ORs per-element outlier flags into a column mask, then replays the tile split into FP16/int8 streams.
// Optional OUTLIER_COUNT_EN adds an outlier_count output (popcount of the column mask).
module outlier_split #(
   parameter int IN_WIDTH       = 16,
   parameter int IN_SIZE        = 4,
   parameter int IN_PARALLELISM = 1,
   parameter int IN_DEPTH       = 4
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_in,
   input  logic [IN_SIZE*IN_PARALLELISM-1:0]                ind_table,
   input  logic                                             data_in_valid,
   output logic                                             data_in_ready,
   output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_out_large,
   output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_out_small,
   output logic [IN_SIZE*IN_PARALLELISM-1:0]                col_mask,
   output logic                                             data_out_last,
   output logic                                             data_out_valid,
   input  logic                                             data_out_ready
`ifdef OUTLIER_COUNT_EN
   ,
   output logic [$clog2(IN_SIZE*IN_PARALLELISM+1)-1:0]      outlier_count
`endif
);

   localparam int N  = IN_SIZE * IN_PARALLELISM;
   localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                        state;
   state_t                        next_state;
   logic [CW-1:0]                 wr_cnt;
   logic [CW-1:0]                 rd_cnt;
   logic [N-1:0]                  col_acc;
   logic [N-1:0]                  mask_q;
   logic [N-1:0]                  next_mask;
   logic [N-1:0][IN_WIDTH-1:0]    tile_mem [2**CW];
   logic [N-1:0][IN_WIDTH-1:0]    beat;
   logic                          fill_fire;
   logic                          drain_fire;
   logic                          wr_last;
   logic                          rd_last;

   assign fill_fire  = rst && (state == FILL) && data_in_valid;
   assign drain_fire = rst && (state == DRAIN) && data_out_ready;
   assign wr_last    = (wr_cnt == CW'(IN_DEPTH - 1));
   assign rd_last    = (rd_cnt == CW'(IN_DEPTH - 1));
   assign next_mask  = col_acc | ind_table;

   always_ff @(posedge clk) begin
      if (!rst) state <= FILL;
      else      state <= next_state;
   end

   // Handshake outputs are gated by rst so they read 0 while reset is held.
   always_comb begin
      next_state     = state;
      data_in_ready  = 1'b0;
      data_out_valid = 1'b0;
      data_out_last  = 1'b0;
      case (state)
         FILL: begin
            data_in_ready = rst;
            if (fill_fire && wr_last) next_state = DRAIN;
         end
         DRAIN: begin
            data_out_valid = rst;
            data_out_last  = rst && rd_last;
            if (drain_fire && rd_last) next_state = FILL;
         end
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         col_acc <= '0;
         mask_q  <= '0;
      end else begin
         if (fill_fire) begin
            col_acc <= next_mask;
            if (wr_last) begin
               wr_cnt <= '0;
               mask_q <= next_mask;
            end else begin
               wr_cnt <= wr_cnt + CW'(1);
            end
         end
         if (drain_fire) begin
            if (rd_last) begin
               rd_cnt  <= '0;
               col_acc <= '0;
            end else begin
               rd_cnt <= rd_cnt + CW'(1);
            end
         end
      end
   end

   // The tile buffer is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (fill_fire) tile_mem[wr_cnt] <= data_in;
   end

   assign col_mask = rst ? mask_q : '0;

   always_comb begin
      beat           = tile_mem[rd_cnt];
      data_out_large = '0;
      data_out_small = '0;
      if (data_out_valid) begin
         for (int i = 0; i < N; i++) begin
            if (mask_q[i]) data_out_large[i] = beat[i];
            else           data_out_small[i] = beat[i];
         end
      end
   end

`ifdef OUTLIER_COUNT_EN
   localparam int PW = $clog2(N + 1);

   logic [PW-1:0] pop_next;
   logic [PW-1:0] count_q;

   always_comb begin
      pop_next = '0;
      for (int i = 0; i < N; i++) pop_next = pop_next + PW'(next_mask[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst)                    count_q <= '0;
      else if (fill_fire && wr_last) count_q <= pop_next;
   end

   assign outlier_count = count_q;
`endif

endmodule

// File: tb/tb_outlier_split.sv
// Self-checking bench for outlier_split: table-driven tiles, corner-case sequences and random tiles vs a tile-level model.
module tb_outlier_split;

   localparam int D = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [3:0][15:0]  data_in;
   logic [3:0]        ind_table;
   logic              data_in_valid;
   logic              data_in_ready;
   logic [3:0][15:0]  data_out_large;
   logic [3:0][15:0]  data_out_small;
   logic [3:0]        col_mask;
   logic              data_out_last;
   logic              data_out_valid;
   logic              data_out_ready;

   logic [3:0][15:0]  d1_data_in;
   logic [3:0]        d1_ind_table;
   logic              d1_data_in_valid;
   logic              d1_data_in_ready;
   logic [3:0][15:0]  d1_data_out_large;
   logic [3:0][15:0]  d1_data_out_small;
   logic [3:0]        d1_col_mask;
   logic              d1_data_out_last;
   logic              d1_data_out_valid;
   logic              d1_data_out_ready;
`ifdef OUTLIER_COUNT_EN
   logic [2:0]        outlier_count;
   logic [2:0]        d1_outlier_count;
`endif

   outlier_split #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .IN_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .ind_table(ind_table),
      .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .data_out_large(data_out_large), .data_out_small(data_out_small),
      .col_mask(col_mask), .data_out_last(data_out_last),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef OUTLIER_COUNT_EN
      , .outlier_count(outlier_count)
`endif
   );

   outlier_split #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .IN_DEPTH(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(d1_data_in), .ind_table(d1_ind_table),
      .data_in_valid(d1_data_in_valid), .data_in_ready(d1_data_in_ready),
      .data_out_large(d1_data_out_large), .data_out_small(d1_data_out_small),
      .col_mask(d1_col_mask), .data_out_last(d1_data_out_last),
      .data_out_valid(d1_data_out_valid), .data_out_ready(d1_data_out_ready)
`ifdef OUTLIER_COUNT_EN
      , .outlier_count(d1_outlier_count)
`endif
   );

   typedef struct {
      logic [15:0] val;
      logic [15:0] flags;
      logic [3:0]  exp_mask;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] tile_data [D];
   logic [3:0]  tile_flags [D];
   logic [63:0] bb_data [12];
   logic [3:0]  bb_flags [12];
   logic [3:0]  bb_mask [3];
   vec_t        vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] model_mask(input logic [3:0] f0, input logic [3:0] f1,
                                             input logic [3:0] f2, input logic [3:0] f3);
      return f0 | f1 | f2 | f3;
   endfunction

   // Keeps elements whose mask bit equals keep_set, zeros the rest.
   function automatic logic [63:0] split_beat(input logic [63:0] d, input logic [3:0] m, input bit keep_set);
      logic [63:0] r;
      r = '0;
      for (int e = 0; e < 4; e++)
         if (m[e] == keep_set) r[16*e +: 16] = d[16*e +: 16];
      return r;
   endfunction

   task automatic apply_stimulus(input logic [63:0] d, input logic [3:0] f);
      int t;
      t = 0;
      data_in       = d;
      ind_table     = f;
      data_in_valid = 1'b1;
      while (!data_in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("in_ready_timeout", 64'(t), 64'd0);
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic fill_tile();
      for (int b = 0; b < D; b++) apply_stimulus(tile_data[b], tile_flags[b]);
   endtask

   task automatic check_output(input logic [3:0] m, input int stall_beat, input int stall_cycles,
                               input bit rand_ready, input string tag);
      int b;
      int t;
      int stall_left;
      b = 0;
      t = 0;
      stall_left = stall_cycles;
      while (b < D && t < 200) begin
         if (b == stall_beat && stall_left > 0) begin
            data_out_ready = 1'b0;
            stall_left--;
         end else begin
            data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (data_out_valid) begin
            check($sformatf("%s.b%0d.large", tag, b), data_out_large, split_beat(tile_data[b], m, 1'b1));
            check($sformatf("%s.b%0d.small", tag, b), data_out_small, split_beat(tile_data[b], m, 1'b0));
            check($sformatf("%s.b%0d.last", tag, b), 64'(data_out_last), 64'(b == D - 1));
            check($sformatf("%s.b%0d.mask", tag, b), 64'(col_mask), 64'(m));
            check($sformatf("%s.b%0d.in_ready", tag, b), 64'(data_in_ready), 64'd0);
`ifdef OUTLIER_COUNT_EN
            check($sformatf("%s.b%0d.count", tag, b), 64'(outlier_count), 64'($countones(m)));
`endif
            if (data_out_ready) b++;
         end
         @(negedge clk);
         t++;
      end
      check($sformatf("%s.beats_out", tag), 64'(b), 64'(D));
      data_out_ready = 1'b1;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{val: 16'h3C00, flags: 16'h0400, exp_mask: 4'b0100};
      vecs[1] = '{val: 16'h1234, flags: 16'h0000, exp_mask: 4'b0000};
      vecs[2] = '{val: 16'hABCD, flags: 16'h8421, exp_mask: 4'b1111};
      vecs[3] = '{val: 16'h7777, flags: 16'h0030, exp_mask: 4'b0011};
      vecs[4] = '{val: 16'h5640, flags: 16'h6100, exp_mask: 4'b0111};

      rst               = 1'b0;
      data_in           = '0;
      ind_table         = '0;
      data_in_valid     = 1'b1;
      data_out_ready    = 1'b1;
      d1_data_in        = '0;
      d1_ind_table      = '0;
      d1_data_in_valid  = 1'b1;
      d1_data_out_ready = 1'b1;

      // Reset held with upstream valid asserted.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst.in_ready", 64'(data_in_ready), 64'd0);
         check("rst.out_valid", 64'(data_out_valid), 64'd0);
         check("rst.col_mask", 64'(col_mask), 64'd0);
         check("rst.d1_in_ready", 64'(d1_data_in_ready), 64'd0);
      end
      data_in_valid    = 1'b0;
      d1_data_in_valid = 1'b0;
      rst              = 1'b1;
      @(negedge clk);
      check("post_rst.in_ready", 64'(data_in_ready), 64'd1);
      check("post_rst.out_valid", 64'(data_out_valid), 64'd0);
`ifdef OUTLIER_COUNT_EN
      check("post_rst.count", 64'(outlier_count), 64'd0);
`endif

      // Table-driven tiles with uniform element values.
      for (int v = 0; v < 5; v++) begin
         for (int b = 0; b < D; b++) begin
            tile_data[b]  = {4{vecs[v].val}};
            tile_flags[b] = vecs[v].flags[4*b +: 4];
         end
         fill_tile();
         check_output(vecs[v].exp_mask, -1, 0, 1'b0, $sformatf("vec%0d", v));
      end

      // Output stall of 5 cycles mid-drain.
      for (int b = 0; b < D; b++) begin
         tile_data[b]  = {16'hA000 + 16'(b), 16'hB000 + 16'(b), 16'hC000 + 16'(b), 16'hD000 + 16'(b)};
         tile_flags[b] = (b == 0) ? 4'b1010 : 4'b0000;
      end
      fill_tile();
      check_output(4'b1010, 2, 5, 1'b0, "stall");

      // Reset after two beats discards the partial tile.
      apply_stimulus(64'h1111_2222_3333_4444, 4'b1111);
      apply_stimulus(64'h5555_6666_7777_8888, 4'b1111);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("midrst.k%0d.out_valid", k), 64'(data_out_valid), 64'd0);
         @(negedge clk);
      end
      for (int b = 0; b < D; b++) begin
         tile_data[b]  = {$urandom, $urandom};
         tile_flags[b] = 4'b0000;
      end
      fill_tile();
      check_output(4'b0000, -1, 0, 1'b0, "midrst");

      // Single-beat tile on the depth-1 instance.
      d1_data_in       = {4{16'h5640}};
      d1_ind_table     = 4'b1111;
      d1_data_in_valid = 1'b1;
      @(negedge clk);
      d1_data_in_valid = 1'b0;
      check("d1.out_valid", 64'(d1_data_out_valid), 64'd1);
      check("d1.large", d1_data_out_large, {4{16'h5640}});
      check("d1.small", d1_data_out_small, 64'd0);
      check("d1.last", 64'(d1_data_out_last), 64'd1);
      check("d1.mask", 64'(d1_col_mask), 64'hF);
`ifdef OUTLIER_COUNT_EN
      check("d1.count", 64'(d1_outlier_count), 64'd4);
`endif
      @(negedge clk);
      check("d1.after.out_valid", 64'(d1_data_out_valid), 64'd0);
      check("d1.after.in_ready", 64'(d1_data_in_ready), 64'd1);

      // Back-to-back tiles with downstream always ready.
      for (int i = 0; i < 12; i++) begin
         bb_data[i]  = {$urandom, $urandom};
         bb_flags[i] = 4'b0000;
      end
      bb_flags[1] = 4'b1001;
      for (int i = 8; i < 12; i++) bb_flags[i] = 4'($urandom_range(0, 15));
      for (int t = 0; t < 3; t++)
         bb_mask[t] = model_mask(bb_flags[4*t], bb_flags[4*t+1], bb_flags[4*t+2], bb_flags[4*t+3]);
      data_out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 12; i++) apply_stimulus(bb_data[i], bb_flags[i]);
         end
         begin
            for (int k = 0; k < 24; k++) begin
               check($sformatf("b2b.k%0d.valid", k), 64'(data_out_valid), 64'(((k / 4) % 2) == 1));
               if ((k % 8) >= 4) begin
                  check($sformatf("b2b.k%0d.mask", k), 64'(col_mask), 64'(bb_mask[k / 8]));
                  check($sformatf("b2b.k%0d.large", k), data_out_large,
                        split_beat(bb_data[4 * (k / 8) + (k % 4)], bb_mask[k / 8], 1'b1));
               end
               @(negedge clk);
            end
         end
      join
      check("b2b.tileB.mask_clear", 64'(bb_mask[1]), 64'd0);

      // Random tiles with random downstream backpressure.
      for (int r = 0; r < 20; r++) begin
         for (int b = 0; b < D; b++) begin
            tile_data[b]  = {$urandom, $urandom};
            tile_flags[b] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         end
         fill_tile();
         check_output(model_mask(tile_flags[0], tile_flags[1], tile_flags[2], tile_flags[3]),
                      -1, 0, 1'b1, $sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
